// File: rtl/regfile_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_pkg
// Shared constants for the register-file write arbiter slice.
// Holds the default sizes, the hardwired-zero register index and the width
// of the grant index carried on grant_id and the round-robin pointer.
// ---------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF = 3;
    localparam int unsigned ADDR_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned CNT_W_DEF   = 16;

    // $zero is hardwired; writes to it are swallowed at the handshake.
    localparam int unsigned REG_ZERO    = 0;

    // Wide enough for up to four requesters.
    localparam int unsigned GRANT_W     = 2;

    // Width of the pending-write scoreboard (one bit per architectural register).
    localparam int unsigned PEND_W      = 32;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
// Bundles the requester handshake and the register-file write port.
//   req_valid/req_ready/req_addr/req_data : per-requester write handshake
//   rf_rw/rf_addr/rf_data                 : registered register-file write port
//   grant_id                              : requester currently on rf_*
//   pend_mask                             : registers with writes in flight
//   commit_count                          : wrapping count of driven writes
// Modports: slave = arbiter side, master = requester/register-file side.
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;

    logic                      rf_rw;
    logic [ADDR_W-1:0]         rf_addr;
    logic [DATA_W-1:0]         rf_data;
    logic [GRANT_W-1:0]        grant_id;
    logic [PEND_W-1:0]         pend_mask;
    logic [CNT_W-1:0]          commit_count;

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rf_rw, rf_addr, rf_data, grant_id, pend_mask, commit_count
    );

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rf_rw, rf_addr, rf_data, grant_id, pend_mask, commit_count
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_rr_arbiter
// Purely combinational round-robin picker.
//   i_req   : request vector (one bit per requester)
//   i_ptr   : index of the last winner; search starts at i_ptr+1 mod NUM_REQ
//   o_gnt   : one-hot grant
//   o_idx   : index of the granted requester
//   o_valid : at least one request present
// ---------------------------------------------------------------------------
module regfile_write_arbiter_rr_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GRANT_W-1:0] i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [GRANT_W-1:0] o_idx,
    output logic               o_valid
);

    logic [GRANT_W-1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        // Walk NUM_REQ positions after the pointer; the pointer itself is visited last.
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            w_cand = GRANT_W'((int'(i_ptr) + k) % int'(NUM_REQ));
            if (!o_valid && i_req[w_cand]) begin
                o_valid       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the register file's single write port between NUM_REQ write-back
// requesters. Each requester owns a one-entry slot; a round-robin arbiter
// drains one full slot per cycle into a registered write port (rf_*), which
// the register file commits on the following negedge.
//   clk   : system clock, all state updates on posedge
//   rst_n : asynchronous active-low reset
//   bus   : requester handshake, write port, scoreboard and commit counter
// ---------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    regfile_write_arbiter_if.slave        bus
);

    logic [NUM_REQ-1:0] r_slot_full;
    logic [ADDR_W-1:0]  r_slot_addr [NUM_REQ];
    logic [DATA_W-1:0]  r_slot_data [NUM_REQ];

    logic               r_rf_rw;
    logic [ADDR_W-1:0]  r_rf_addr;
    logic [DATA_W-1:0]  r_rf_data;
    logic [GRANT_W-1:0] r_grant_id;
    logic [GRANT_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0]   r_commit_count;

    logic [ADDR_W-1:0]  w_req_addr [NUM_REQ];
    logic [DATA_W-1:0]  w_req_data [NUM_REQ];
    logic [NUM_REQ-1:0] w_fill;
    logic [NUM_REQ-1:0] w_gnt;
    logic [GRANT_W-1:0] w_gnt_idx;
    logic               w_gnt_valid;
    logic [PEND_W-1:0]  w_pend;

    // Unpack requester fields; a write to $zero completes the handshake but
    // never occupies the slot.
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_req_addr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
            w_req_data[i] = bus.req_data[i*DATA_W +: DATA_W];
            w_fill[i]     = bus.req_valid[i] & ~r_slot_full[i] &
                            (w_req_addr[i] != ADDR_W'(REG_ZERO));
        end
    end

    regfile_write_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (r_slot_full),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_gnt_idx),
        .o_valid (w_gnt_valid)
    );

    // Slots. Fill and grant never hit the same slot on one edge: fill needs it
    // empty, grant needs it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_full <= '0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                r_slot_addr[i] <= '0;
                r_slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (w_gnt[i]) begin
                    r_slot_full[i] <= 1'b0;
                end else if (w_fill[i]) begin
                    r_slot_full[i] <= 1'b1;
                    r_slot_addr[i] <= w_req_addr[i];
                    r_slot_data[i] <= w_req_data[i];
                end
            end
        end
    end

    // Registered write port. The async reset also kills rf_rw mid-cycle so the
    // register file sees no negedge write after reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_rw        <= 1'b0;
            r_rf_addr      <= '0;
            r_rf_data      <= '0;
            r_grant_id     <= '0;
            r_rr_ptr       <= GRANT_W'(NUM_REQ - 1);
            r_commit_count <= '0;
        end else if (w_gnt_valid) begin
            r_rf_rw        <= 1'b1;
            r_rf_addr      <= r_slot_addr[w_gnt_idx];
            r_rf_data      <= r_slot_data[w_gnt_idx];
            r_grant_id     <= w_gnt_idx;
            r_rr_ptr       <= w_gnt_idx;
            r_commit_count <= r_commit_count + CNT_W'(1);
        end else begin
            r_rf_rw        <= 1'b0;
        end
    end

    // Scoreboard: everything sitting in a slot or on the write port this cycle.
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (r_slot_full[i]) begin
                w_pend[r_slot_addr[i]] = 1'b1;
            end
        end
        if (r_rf_rw) begin
            w_pend[r_rf_addr] = 1'b1;
        end
        w_pend[REG_ZERO] = 1'b0;
    end

    assign bus.req_ready    = ~r_slot_full;
    assign bus.rf_rw        = r_rf_rw;
    assign bus.rf_addr      = r_rf_addr;
    assign bus.rf_data      = r_rf_data;
    assign bus.grant_id     = r_grant_id;
    assign bus.pend_mask    = w_pend;
    assign bus.commit_count = r_commit_count;

endmodule
